// File: rtl/fpu_rb_pkg.sv
// rtl/fpu_rb_pkg.sv - shared types and widths for the FPU result buffer
package fpu_rb_pkg;

    localparam int STATUS_W = 5;
    localparam int RESULT_W = 64;
    localparam int TAG_W    = 3;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        status_t             status;
        logic [TAG_W-1:0]    tag;
    } entry_t;

endpackage

// File: rtl/fpu_rb_store.sv
// rtl/fpu_rb_store.sv - DEPTH-entry register array, one write port, async read port
module fpu_rb_store #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 72,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Data is never reset; validity is tracked by the occupancy counter.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpu_result_buffer.sv
// rtl/fpu_result_buffer.sv - credit-counted ring buffer for FPU results; FPU_RESULT_BYPASS_EN enables 0-latency bypass
module fpu_result_buffer
    import fpu_rb_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 3,
    parameter int DEPTH     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     fpu_valid_i,
    input  logic [WIDTH-1:0]         fpu_result_i,
    input  logic [4:0]               fpu_status_i,
    input  logic [TAG_WIDTH-1:0]     fpu_tag_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [WIDTH-1:0]         wb_result_o,
    output logic [4:0]               wb_status_o,
    output logic [TAG_WIDTH-1:0]     wb_tag_o,
    output logic [4:0]               fflags_o,
    input  logic                     fflags_clr_i,
    output logic [$clog2(DEPTH):0]   inflight_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + STATUS_W + TAG_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    status_t          fflags_q, fflags_d;
    logic             err_q, err_d;

    logic [ENT_W-1:0] wr_ent, rd_ent;
    logic             issue_fire, ret_ok, room, pop, byp_pop, buf_pop, store_we, drop;
    logic             byp_active;
    logic [WIDTH-1:0]     head_result;
    logic [4:0]           head_status;
    logic [TAG_WIDTH-1:0] head_tag;

    assign inflight_o    = pending_q + occ_q;
    assign issue_ready_o = inflight_o < DEPTH_C;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign ret_ok        = fpu_valid_i && (pending_q != '0);

`ifdef FPU_RESULT_BYPASS_EN
    assign byp_active = (occ_q == '0) && ret_ok;
`else
    assign byp_active = 1'b0;
`endif

    assign wb_valid_o = (occ_q != '0) || byp_active;
    assign pop        = wb_valid_o && wb_ready_i;
    assign byp_pop    = byp_active && wb_ready_i;
    assign buf_pop    = pop && !byp_pop;
    // A full buffer can still accept a result when the head leaves in the same cycle.
    assign room       = (occ_q != DEPTH_C) || pop;
    assign store_we   = ret_ok && room && !byp_pop && !flush_i;
    assign drop       = fpu_valid_i && !(ret_ok && room);

    assign wr_ent = {fpu_result_i, fpu_status_i, fpu_tag_i};

    fpu_rb_store #(
        .DEPTH  (DEPTH),
        .DATA_W (ENT_W),
        .ADDR_W (PTR_W)
    ) u_store (
        .clk_i   (clk_i),
        .we_i    (store_we),
        .waddr_i (wptr_q),
        .wdata_i (wr_ent),
        .raddr_i (rptr_q),
        .rdata_o (rd_ent)
    );

    always_comb begin
        head_result = rd_ent[ENT_W-1 -: WIDTH];
        head_status = rd_ent[TAG_WIDTH +: STATUS_W];
        head_tag    = rd_ent[TAG_WIDTH-1:0];
        if (byp_active) begin
            head_result = fpu_result_i;
            head_status = fpu_status_i;
            head_tag    = fpu_tag_i;
        end
    end

    // Outputs read as zero when idle so unwritten storage never leaks out.
    assign wb_result_o = wb_valid_o ? head_result : '0;
    assign wb_status_o = wb_valid_o ? head_status : '0;
    assign wb_tag_o    = wb_valid_o ? head_tag    : '0;
    assign fflags_o    = fflags_q;
    assign err_o       = err_q;

    always_comb begin
        pending_d = pending_q;
        occ_d     = occ_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        fflags_d  = fflags_q;
        err_d     = err_q;
        if (flush_i) begin
            pending_d = '0;
            occ_d     = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            if (fflags_clr_i) begin
                fflags_d = '0;
            end
        end else begin
            pending_d = pending_q + CNT_W'(issue_fire) - CNT_W'(ret_ok);
            occ_d     = occ_q + CNT_W'(store_we) - CNT_W'(buf_pop);
            wptr_d    = wptr_q + PTR_W'(store_we);
            rptr_d    = rptr_q + PTR_W'(buf_pop);
            fflags_d  = (fflags_clr_i ? status_t'('0) : fflags_q)
                      | (pop ? status_t'(wb_status_o) : status_t'('0));
            if (drop) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            occ_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fflags_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            occ_q     <= occ_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            fflags_q  <= fflags_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb/tb_fpu_result_buffer.sv - scoreboard bench for fpu_result_buffer
module tb_fpu_result_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic        fpu_valid_i;
    logic [63:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic [2:0]  fpu_tag_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [63:0] wb_result_o;
    logic [4:0]  wb_status_o;
    logic [2:0]  wb_tag_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic [2:0]  inflight_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    logic [71:0] sb_q[$];

    fpu_result_buffer #(.WIDTH(64), .TAG_WIDTH(3), .DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .fpu_valid_i   (fpu_valid_i),
        .fpu_result_i  (fpu_result_i),
        .fpu_status_i  (fpu_status_i),
        .fpu_tag_i     (fpu_tag_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_result_o   (wb_result_o),
        .wb_status_o   (wb_status_o),
        .wb_tag_o      (wb_tag_o),
        .fflags_o      (fflags_o),
        .fflags_clr_i  (fflags_clr_i),
        .inflight_o    (inflight_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every accepted writeback must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (!rst_i && wb_valid_o && wb_ready_i) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got tag=%0d result=%h, expected no output", wb_tag_o, wb_result_o);
            end else begin
                logic [71:0] exp;
                exp = sb_q.pop_front();
                if ({wb_result_o, wb_status_o, wb_tag_o} !== exp) begin
                    errors++;
                    $display("FAIL wb_data: got %h/%b/%0d, expected %h/%b/%0d",
                             wb_result_o, wb_status_o, wb_tag_o, exp[71:8], exp[7:3], exp[2:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_n(input int n);
        issue_valid_i = 1'b1;
        repeat (n) step();
        issue_valid_i = 1'b0;
    endtask

    task automatic ret(input logic [63:0] res, input logic [4:0] st, input logic [2:0] tag, input bit expect_out);
        fpu_valid_i  = 1'b1;
        fpu_result_i = res;
        fpu_status_i = st;
        fpu_tag_i    = tag;
        if (expect_out) sb_q.push_back({res, st, tag});
        step();
        fpu_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; fpu_valid_i = 1'b0;
        fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
        wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
        repeat (3) step();
        chk("rst_issue_ready", issue_ready_o, 1);
        rst_i = 1'b0;
        step();
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_fflags", fflags_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_wb_result", wb_result_o, 0);

        // Single op, 3-cycle FPU latency
        issue_n(1);
        chk("single_inflight", inflight_o, 1);
        step(); step();
        ret(64'h4000_0000_0000_0000, 5'b00001, 3'd3, 1);
        chk("single_wb_valid", wb_valid_o, 1);
        wb_ready_i = 1'b1; step(); wb_ready_i = 1'b0;
        chk("single_fflags", fflags_o, 5'b00001);
        chk("single_empty", wb_valid_o, 0);

        // Fill all credits, hold writeback
        issue_n(4);
        chk("fill_ready_low", issue_ready_o, 0);
        issue_n(1);
        chk("fill_issue_ignored", inflight_o, 4);
        for (int i = 0; i < 4; i++) ret(64'h100 + 64'(i), 5'b0, 3'(i), 1);
        chk("fill_inflight", inflight_o, 4);
        chk("fill_ready_still_low", issue_ready_o, 0);
        chk("fill_head_tag", wb_tag_o, 0);
        wb_ready_i = 1'b1; step();
        chk("fill_ready_after_pop", issue_ready_o, 1);
        step(); step(); step();
        wb_ready_i = 1'b0;
        chk("fill_drained", wb_valid_o, 0);

        // Back-to-back ops across pointer wrap
        wb_ready_i = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            issue_valid_i = (i < 10);
            fpu_valid_i   = (i > 0);
            if (i > 0) begin
                fpu_result_i = 64'(i) * 64'h1111;
                fpu_status_i = 5'b0;
                fpu_tag_i    = 3'(i - 1);
                sb_q.push_back({64'(i) * 64'h1111, 5'b0, 3'(i - 1)});
            end
            step();
        end
        issue_valid_i = 1'b0; fpu_valid_i = 1'b0;
        step(); step();
        wb_ready_i = 1'b0;
        chk("wrap_inflight", inflight_o, 0);
        chk("wrap_err", err_o, 0);

        // Sticky flags and clear-with-pop
        fflags_clr_i = 1'b1; step(); fflags_clr_i = 1'b0;
        chk("flags_cleared", fflags_o, 0);
        issue_n(2);
        ret(64'hA, 5'b10000, 3'd1, 1);
        ret(64'hB, 5'b00100, 3'd2, 1);
        wb_ready_i = 1'b1; step(); step(); wb_ready_i = 1'b0;
        chk("flags_or", fflags_o, 5'b10100);
        issue_n(1);
        ret(64'hC, 5'b00010, 3'd4, 1);
        wb_ready_i = 1'b1; fflags_clr_i = 1'b1; step();
        wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
        chk("flags_clr_pop", fflags_o, 5'b00010);

        // Flush with 2 buffered, 1 pending
        issue_n(3);
        ret(64'hD, 5'b0, 3'd5, 0);
        ret(64'hE, 5'b0, 3'd6, 0);
        chk("flush_pre_inflight", inflight_o, 3);
        flush_i = 1'b1; step(); flush_i = 1'b0;
        chk("flush_wb_valid", wb_valid_o, 0);
        chk("flush_inflight", inflight_o, 0);
        chk("flush_ready", issue_ready_o, 1);
        chk("flush_err_before_late", err_o, 0);
        ret(64'hF, 5'b0, 3'd7, 0);
        chk("late_err", err_o, 1);
        chk("late_no_valid", wb_valid_o, 0);
        chk("flush_fflags_kept", fflags_o, 5'b00010);

        // Asynchronous reset mid-stream
        issue_n(3);
        for (int i = 0; i < 3; i++) ret(64'h200 + 64'(i), 5'b01000, 3'(i), 0);
        chk("mid_inflight", inflight_o, 3);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_wb_valid", wb_valid_o, 0);
        chk("arst_ready", issue_ready_o, 1);
        chk("arst_fflags", fflags_o, 0);
        chk("arst_err", err_o, 0);
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_inflight", inflight_o, 0);
        chk("sb_empty", 64'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
